// File: rtl/pbs_pkg.sv
// Shared types and constants for the battle turn sequencer and its datapath.
package pbs_pkg;

    localparam int unsigned HP_W   = 4;
    localparam int unsigned CNT_W  = 4;
    localparam int unsigned TURN_W = 8;
    localparam int unsigned MOVE_W = 2;

    localparam logic [HP_W-1:0] MAX_HP = 4'd9;

    localparam logic ACT_PLAYER = 1'b0;
    localparam logic ACT_AI     = 1'b1;
    localparam logic TGT_PLAYER = 1'b0;
    localparam logic TGT_AI     = 1'b1;

    typedef enum logic [3:0] {
        IDLE,
        P_SEL,
        P_CALC,
        P_APPLY,
        P_WAIT,
        P_CHECK,
        A_SEL,
        A_CALC,
        A_APPLY,
        A_WAIT,
        A_CHECK,
        OVER
    } state_t;

    // Control strobes driven into pbs_dp
    typedef struct packed {
        logic actr;
        logic target;
        logic calc_dmg;
        logic app_dmg;
    } dp_ctrl_t;

    // HP above MAX_HP can only come from a 4-bit underflow, so it counts as zero
    function automatic logic is_knockout(input logic [HP_W-1:0] hp);
        return (hp == '0) || (hp > MAX_HP);
    endfunction

endpackage

// File: rtl/pbs_settle_cnt.sv
// Load/decrement settle counter shared by the SEL and WAIT states.
module pbs_settle_cnt
    import pbs_pkg::*;
(
    input  logic             clk,
    input  logic             i_rst_n,
    input  logic             i_load,
    input  logic [CNT_W-1:0] i_load_val,
    input  logic             i_dec,
    output logic             o_done_c
);

    logic [CNT_W-1:0] r_cnt;

    always_ff @(posedge clk) begin
        if (!i_rst_n) begin
            r_cnt <= '0;
        end else if (i_load) begin
            r_cnt <= i_load_val;
        end else if (i_dec && (r_cnt != '0)) begin
            r_cnt <= r_cnt - CNT_W'(1);
        end
    end

    assign o_done_c = (r_cnt == '0);

endmodule

// File: rtl/pbs_turn_ctrl.sv
// Turn sequencer: player half-turn, AI half-turn, knockout check and winner latch.
// Outputs are decoded from the next state and registered alongside it.
module pbs_turn_ctrl
    import pbs_pkg::*;
#(
    parameter int unsigned SETTLE_CYCLES = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              move_valid,
    input  logic [MOVE_W-1:0] p_move_in,
    input  logic [HP_W-1:0]   p_hp,
    input  logic [HP_W-1:0]   AI_hp,
    output logic              move_ready,
    output logic [MOVE_W-1:0] p_move,
    output logic              actr,
    output logic              target,
    output logic              calc_dmg,
    output logic              app_dmg,
    output logic              game_over,
    output logic              winner,
    output logic [TURN_W-1:0] turn_cnt
);

    // Counter is reloaded on entry, so it holds S-1 during the first cycle of SEL/WAIT
    localparam logic [CNT_W-1:0] SETTLE_LOAD = CNT_W'(SETTLE_CYCLES - 1);

    state_t              r_state;
    state_t              w_state_next;
    dp_ctrl_t            r_ctrl;
    dp_ctrl_t            w_ctrl_next;
    logic                r_move_ready;
    logic                w_move_ready_next;
    logic                r_game_over;
    logic                w_game_over_next;
    logic [MOVE_W-1:0]   r_p_move;
    logic [MOVE_W-1:0]   w_p_move_next;
    logic                r_winner;
    logic                w_winner_next;
    logic [TURN_W-1:0]   r_turn_cnt;
    logic [TURN_W-1:0]   w_turn_cnt_next;
    logic                w_cnt_load;
    logic                w_cnt_dec;
    logic                w_cnt_done;

    pbs_settle_cnt u_settle_cnt (
        .clk        (clk),
        .i_rst_n    (rst),
        .i_load     (w_cnt_load),
        .i_load_val (SETTLE_LOAD),
        .i_dec      (w_cnt_dec),
        .o_done_c   (w_cnt_done)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            r_state      <= IDLE;
            r_ctrl       <= '0;
            r_move_ready <= 1'b1;
            r_game_over  <= 1'b0;
            r_p_move     <= '0;
            r_winner     <= 1'b0;
            r_turn_cnt   <= '0;
        end else begin
            r_state      <= w_state_next;
            r_ctrl       <= w_ctrl_next;
            r_move_ready <= w_move_ready_next;
            r_game_over  <= w_game_over_next;
            r_p_move     <= w_p_move_next;
            r_winner     <= w_winner_next;
            r_turn_cnt   <= w_turn_cnt_next;
        end
    end

    // Next-state, latched data and settle-counter control
    always_comb begin
        w_state_next    = r_state;
        w_p_move_next   = r_p_move;
        w_winner_next   = r_winner;
        w_turn_cnt_next = r_turn_cnt;
        w_cnt_load      = 1'b0;
        w_cnt_dec       = 1'b0;
        case (r_state)
            IDLE: begin
                if (move_valid) begin
                    w_state_next  = P_SEL;
                    w_p_move_next = p_move_in;
                    w_cnt_load    = 1'b1;
                end
            end
            P_SEL: begin
                if (w_cnt_done) w_state_next = P_CALC;
                else            w_cnt_dec    = 1'b1;
            end
            P_CALC:  w_state_next = P_APPLY;
            P_APPLY: begin
                w_state_next = P_WAIT;
                w_cnt_load   = 1'b1;
            end
            P_WAIT: begin
                if (w_cnt_done) w_state_next = P_CHECK;
                else            w_cnt_dec    = 1'b1;
            end
            P_CHECK: begin
                if (is_knockout(AI_hp)) begin
                    w_state_next  = OVER;
                    w_winner_next = 1'b0;
                end else begin
                    w_state_next = A_SEL;
                    w_cnt_load   = 1'b1;
                end
            end
            A_SEL: begin
                if (w_cnt_done) w_state_next = A_CALC;
                else            w_cnt_dec    = 1'b1;
            end
            A_CALC:  w_state_next = A_APPLY;
            A_APPLY: begin
                w_state_next = A_WAIT;
                w_cnt_load   = 1'b1;
            end
            A_WAIT: begin
                if (w_cnt_done) w_state_next = A_CHECK;
                else            w_cnt_dec    = 1'b1;
            end
            A_CHECK: begin
                if (is_knockout(p_hp)) begin
                    w_state_next  = OVER;
                    w_winner_next = 1'b1;
                end else begin
                    w_state_next = IDLE;
                    if (r_turn_cnt != {TURN_W{1'b1}}) begin
                        w_turn_cnt_next = r_turn_cnt + TURN_W'(1);
                    end
                end
            end
            OVER:    w_state_next = OVER;
            default: w_state_next = IDLE;
        endcase
    end

    // Moore decode of the state being entered
    always_comb begin
        w_ctrl_next       = '0;
        w_move_ready_next = 1'b0;
        w_game_over_next  = 1'b0;
        case (w_state_next)
            IDLE: w_move_ready_next = 1'b1;
            P_SEL, P_CALC, P_APPLY, P_WAIT, P_CHECK: begin
                w_ctrl_next.actr   = ACT_PLAYER;
                w_ctrl_next.target = TGT_AI;
            end
            A_SEL, A_CALC, A_APPLY, A_WAIT, A_CHECK: begin
                w_ctrl_next.actr   = ACT_AI;
                w_ctrl_next.target = TGT_PLAYER;
            end
            OVER:    w_game_over_next = 1'b1;
            default: w_ctrl_next      = '0;
        endcase
        w_ctrl_next.calc_dmg = (w_state_next == P_CALC)  || (w_state_next == A_CALC);
        w_ctrl_next.app_dmg  = (w_state_next == P_APPLY) || (w_state_next == A_APPLY);
    end

    assign move_ready = r_move_ready;
    assign p_move     = r_p_move;
    assign actr       = r_ctrl.actr;
    assign target     = r_ctrl.target;
    assign calc_dmg   = r_ctrl.calc_dmg;
    assign app_dmg    = r_ctrl.app_dmg;
    assign game_over  = r_game_over;
    assign winner     = r_winner;
    assign turn_cnt   = r_turn_cnt;

endmodule

// File: tb/tb_pbs_turn_ctrl.sv
// Directed bench for pbs_turn_ctrl with S=2; cycle c is the cycle after accept edge c-1.
module tb_pbs_turn_ctrl;

    localparam int unsigned S = 2;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       move_valid = 1'b0;
    logic [1:0] p_move_in = 2'b00;
    logic [3:0] p_hp = 4'd9;
    logic [3:0] AI_hp = 4'd9;
    logic       move_ready;
    logic [1:0] p_move;
    logic       actr;
    logic       target;
    logic       calc_dmg;
    logic       app_dmg;
    logic       game_over;
    logic       winner;
    logic [7:0] turn_cnt;

    int checks = 0;
    int failures = 0;
    int exp_turns = 0;

    always #5 clk = ~clk;

    pbs_turn_ctrl #(.SETTLE_CYCLES(S)) dut (
        .clk        (clk),
        .rst        (rst),
        .move_valid (move_valid),
        .p_move_in  (p_move_in),
        .p_hp       (p_hp),
        .AI_hp      (AI_hp),
        .move_ready (move_ready),
        .p_move     (p_move),
        .actr       (actr),
        .target     (target),
        .calc_dmg   (calc_dmg),
        .app_dmg    (app_dmg),
        .game_over  (game_over),
        .winner     (winner),
        .turn_cnt   (turn_cnt)
    );

    // Present a move for one edge; caller is in the low clock phase with the DUT in IDLE
    task automatic accept(input logic [1:0] mv);
        move_valid = 1'b1;
        p_move_in  = mv;
        @(posedge clk);
        #1;
        move_valid = 1'b0;
        p_move_in  = ~mv;
    endtask

    task automatic test_reset();
        @(negedge clk);
        rst = 1'b0;
        move_valid = 1'b0;
        AI_hp = 4'd9;
        p_hp = 4'd9;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks += 9;
        if (move_ready !== 1'b1) begin failures++; $display("FAIL reset_move_ready got=%b exp=1", move_ready); end
        if (p_move !== 2'b00)    begin failures++; $display("FAIL reset_p_move got=%b exp=00", p_move); end
        if (actr !== 1'b0)       begin failures++; $display("FAIL reset_actr got=%b exp=0", actr); end
        if (target !== 1'b0)     begin failures++; $display("FAIL reset_target got=%b exp=0", target); end
        if (calc_dmg !== 1'b0)   begin failures++; $display("FAIL reset_calc got=%b exp=0", calc_dmg); end
        if (app_dmg !== 1'b0)    begin failures++; $display("FAIL reset_app got=%b exp=0", app_dmg); end
        if (game_over !== 1'b0)  begin failures++; $display("FAIL reset_game_over got=%b exp=0", game_over); end
        if (winner !== 1'b0)     begin failures++; $display("FAIL reset_winner got=%b exp=0", winner); end
        if (turn_cnt !== 8'd0)   begin failures++; $display("FAIL reset_turn_cnt got=%0d exp=0", turn_cnt); end
        rst = 1'b1;
        exp_turns = 0;
    endtask

    // Full turn with a transient AI_hp=0 outside P_CHECK that must be ignored
    task automatic test_full_turn();
        logic ec, ea, er, eact, etgt;
        accept(2'b10);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            ec   = (c == 3) || (c == 10);
            ea   = (c == 4) || (c == 11);
            er   = (c == 15);
            eact = (c >= 8) && (c <= 14);
            etgt = (c >= 1) && (c <= 7);
            checks += 5;
            if (calc_dmg !== ec)   begin failures++; $display("FAIL full_calc c=%0d got=%b exp=%b", c, calc_dmg, ec); end
            if (app_dmg !== ea)    begin failures++; $display("FAIL full_app c=%0d got=%b exp=%b", c, app_dmg, ea); end
            if (move_ready !== er) begin failures++; $display("FAIL full_ready c=%0d got=%b exp=%b", c, move_ready, er); end
            if (actr !== eact)     begin failures++; $display("FAIL full_actr c=%0d got=%b exp=%b", c, actr, eact); end
            if (target !== etgt)   begin failures++; $display("FAIL full_target c=%0d got=%b exp=%b", c, target, etgt); end
            if (c == 2) AI_hp = 4'd0;
            if (c == 5) AI_hp = 4'd9;
        end
        exp_turns++;
        checks += 3;
        if (p_move !== 2'b10)             begin failures++; $display("FAIL full_p_move got=%b exp=10", p_move); end
        if (turn_cnt !== 8'(exp_turns))   begin failures++; $display("FAIL full_turn_cnt got=%0d exp=%0d", turn_cnt, exp_turns); end
        if (game_over !== 1'b0)           begin failures++; $display("FAIL full_game_over got=%b exp=0", game_over); end
    endtask

    task automatic test_back_to_back();
        logic [1:0] mv;
        logic ec, er;
        for (int t = 0; t < 2; t++) begin
            mv = (t == 0) ? 2'b01 : 2'b11;
            accept(mv);
            for (int c = 1; c <= 15; c++) begin
                @(negedge clk);
                ec = (c == 3) || (c == 10);
                er = (c == 15);
                checks += 3;
                if (calc_dmg !== ec)   begin failures++; $display("FAIL b2b_calc t=%0d c=%0d got=%b exp=%b", t, c, calc_dmg, ec); end
                if (move_ready !== er) begin failures++; $display("FAIL b2b_ready t=%0d c=%0d got=%b exp=%b", t, c, move_ready, er); end
                if (p_move !== mv)     begin failures++; $display("FAIL b2b_p_move t=%0d c=%0d got=%b exp=%b", t, c, p_move, mv); end
            end
            exp_turns++;
            checks++;
            if (turn_cnt !== 8'(exp_turns)) begin failures++; $display("FAIL b2b_turn_cnt got=%0d exp=%0d", turn_cnt, exp_turns); end
        end
    endtask

    task automatic test_move_during_wait();
        logic er;
        accept(2'b01);
        for (int c = 1; c <= 17; c++) begin
            @(negedge clk);
            er = (c >= 15);
            checks += 2;
            if (p_move !== 2'b01)  begin failures++; $display("FAIL wait_p_move c=%0d got=%b exp=01", c, p_move); end
            if (move_ready !== er) begin failures++; $display("FAIL wait_ready c=%0d got=%b exp=%b", c, move_ready, er); end
            if (c == 12) begin move_valid = 1'b1; p_move_in = 2'b11; end
            if (c == 14) move_valid = 1'b0;
        end
        exp_turns++;
        checks++;
        if (turn_cnt !== 8'(exp_turns)) begin failures++; $display("FAIL wait_turn_cnt got=%0d exp=%0d", turn_cnt, exp_turns); end
    endtask

    task automatic test_player_ko();
        logic ec, ea, eg;
        accept(2'b01);
        for (int c = 1; c <= 25; c++) begin
            @(negedge clk);
            ec = (c == 3);
            ea = (c == 4);
            eg = (c >= 8);
            checks += 6;
            if (calc_dmg !== ec)     begin failures++; $display("FAIL pko_calc c=%0d got=%b exp=%b", c, calc_dmg, ec); end
            if (app_dmg !== ea)      begin failures++; $display("FAIL pko_app c=%0d got=%b exp=%b", c, app_dmg, ea); end
            if (game_over !== eg)    begin failures++; $display("FAIL pko_game_over c=%0d got=%b exp=%b", c, game_over, eg); end
            if (actr !== 1'b0)       begin failures++; $display("FAIL pko_actr c=%0d got=%b exp=0", c, actr); end
            if (move_ready !== 1'b0) begin failures++; $display("FAIL pko_ready c=%0d got=%b exp=0", c, move_ready); end
            if (eg && (winner !== 1'b0)) begin failures++; $display("FAIL pko_winner c=%0d got=%b exp=0", c, winner); end
            if (c == 5)  AI_hp = 4'd0;
            if (c == 10) begin move_valid = 1'b1; p_move_in = 2'b10; end
            if (c == 11) move_valid = 1'b0;
        end
        checks += 2;
        if (turn_cnt !== 8'(exp_turns)) begin failures++; $display("FAIL pko_turn_cnt got=%0d exp=%0d", turn_cnt, exp_turns); end
        if (p_move !== 2'b01)           begin failures++; $display("FAIL pko_p_move got=%b exp=01", p_move); end
    endtask

    // AI_hp=5 survives P_CHECK; p_hp=F is a wrapped underflow and knocks the player out
    task automatic test_ai_ko_wrap();
        logic ec, eact, eg;
        AI_hp = 4'd5;
        p_hp  = 4'hF;
        accept(2'b10);
        for (int c = 1; c <= 18; c++) begin
            @(negedge clk);
            ec   = (c == 3) || (c == 10);
            eact = (c >= 8) && (c <= 14);
            eg   = (c >= 15);
            checks += 4;
            if (calc_dmg !== ec)     begin failures++; $display("FAIL ako_calc c=%0d got=%b exp=%b", c, calc_dmg, ec); end
            if (actr !== eact)       begin failures++; $display("FAIL ako_actr c=%0d got=%b exp=%b", c, actr, eact); end
            if (game_over !== eg)    begin failures++; $display("FAIL ako_game_over c=%0d got=%b exp=%b", c, game_over, eg); end
            if (move_ready !== 1'b0) begin failures++; $display("FAIL ako_ready c=%0d got=%b exp=0", c, move_ready); end
        end
        checks += 2;
        if (winner !== 1'b1)   begin failures++; $display("FAIL ako_winner got=%b exp=1", winner); end
        if (turn_cnt !== 8'd0) begin failures++; $display("FAIL ako_turn_cnt got=%0d exp=0", turn_cnt); end
    endtask

    task automatic test_rst_mid_apply();
        logic ec, er;
        accept(2'b11);
        for (int c = 1; c <= 4; c++) @(negedge clk);
        checks++;
        if (app_dmg !== 1'b1) begin failures++; $display("FAIL mid_app_before got=%b exp=1", app_dmg); end
        rst = 1'b0;
        @(negedge clk);
        checks += 7;
        if (move_ready !== 1'b1) begin failures++; $display("FAIL mid_ready got=%b exp=1", move_ready); end
        if (p_move !== 2'b00)    begin failures++; $display("FAIL mid_p_move got=%b exp=00", p_move); end
        if (actr !== 1'b0)       begin failures++; $display("FAIL mid_actr got=%b exp=0", actr); end
        if (target !== 1'b0)     begin failures++; $display("FAIL mid_target got=%b exp=0", target); end
        if (app_dmg !== 1'b0)    begin failures++; $display("FAIL mid_app got=%b exp=0", app_dmg); end
        if (calc_dmg !== 1'b0)   begin failures++; $display("FAIL mid_calc got=%b exp=0", calc_dmg); end
        if (game_over !== 1'b0)  begin failures++; $display("FAIL mid_game_over got=%b exp=0", game_over); end
        rst = 1'b1;
        exp_turns = 0;
        accept(2'b01);
        for (int c = 1; c <= 15; c++) begin
            @(negedge clk);
            ec = (c == 3) || (c == 10);
            er = (c == 15);
            checks += 2;
            if (calc_dmg !== ec)   begin failures++; $display("FAIL mid_retry_calc c=%0d got=%b exp=%b", c, calc_dmg, ec); end
            if (move_ready !== er) begin failures++; $display("FAIL mid_retry_ready c=%0d got=%b exp=%b", c, move_ready, er); end
        end
        checks++;
        if (turn_cnt !== 8'd1) begin failures++; $display("FAIL mid_retry_turn_cnt got=%0d exp=1", turn_cnt); end
    endtask

    // move_valid held high: one turn every 15 cycles, 300 turns
    task automatic test_saturation();
        move_valid = 1'b1;
        p_move_in  = 2'b00;
        for (int c = 1; c <= 4500; c++) begin
            @(negedge clk);
            if (c == 15 * 254) begin
                checks++;
                if (turn_cnt !== 8'd254) begin failures++; $display("FAIL sat_254 got=%0d exp=254", turn_cnt); end
            end
            if (c == 15 * 255) begin
                checks++;
                if (turn_cnt !== 8'd255) begin failures++; $display("FAIL sat_255 got=%0d exp=255", turn_cnt); end
            end
            if (c == 4500) move_valid = 1'b0;
        end
        for (int c = 0; c < 3; c++) begin
            @(negedge clk);
            checks += 2;
            if (turn_cnt !== 8'd255) begin failures++; $display("FAIL sat_final got=%0d exp=255", turn_cnt); end
            if (move_ready !== 1'b1) begin failures++; $display("FAIL sat_ready got=%b exp=1", move_ready); end
        end
    endtask

    initial begin
        test_reset();
        test_full_turn();
        test_back_to_back();
        test_move_during_wait();
        test_player_ko();
        test_reset();
        test_ai_ko_wrap();
        test_reset();
        test_rst_mid_apply();
        test_reset();
        test_saturation();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pbs_turn_ctrl.md
# pbs_turn_ctrl

Turn sequencer for the battle datapath. Accepts a player move, then drives the datapath control strobes (`actr`, `target`, `calc_dmg`, `app_dmg`) through a player half-turn and an AI half-turn. After each damage application it checks the returned HP for a knockout and latches the winner. It sits between the button/move-select front end and `pbs_dp`, and is the only driver of that datapath's control inputs.

## Interface
- `SETTLE_CYCLES`, default 2: cycles to hold selects before the calc strobe and to wait after the apply strobe, covering datapath register latency. Legal range 1..15.

- `clk`  in  1  system clock
- `rst`  in  1  reset; synchronous, active-low
- `move_valid`  in  1  player move present; sampled only in IDLE
- `p_move_in`  in  2  player move index
- `p_hp`  in  4  player HP from the datapath
- `AI_hp`  in  4  AI HP from the datapath
- `move_ready`  out  1  high in IDLE only
- `p_move`  out  2  latched player move, to the datapath
- `actr`  out  1  0 = player acting, 1 = AI acting
- `target`  out  1  HP being damaged: 0 = player, 1 = AI
- `calc_dmg`  out  1  one-cycle damage-calculate strobe
- `app_dmg`  out  1  one-cycle damage-apply strobe
- `game_over`  out  1  sticky knockout flag
- `winner`  out  1  0 = player won, 1 = AI won; valid when `game_over`=1
- `turn_cnt`  out  8  completed full turns, saturating

## Operation
- States: IDLE, P_SEL, P_CALC, P_APPLY, P_WAIT, P_CHECK, A_SEL, A_CALC, A_APPLY, A_WAIT, A_CHECK, OVER.
- IDLE: `move_ready`=1.
  - If `move_valid`=1, latch `p_move` <= `p_move_in` and go to P_SEL.
  - Otherwise remain in IDLE.
- Player half-turn: `actr`=0, `target`=1, both held from P_SEL through P_CHECK.
- AI half-turn: `actr`=1, `target`=0, both held from A_SEL through A_CHECK.
- SEL state: lasts `SETTLE_CYCLES` cycles, then goes to CALC.
- CALC state: `calc_dmg`=1 for exactly one cycle.
- APPLY state: `app_dmg`=1 for exactly one cycle.
- WAIT state: lasts `SETTLE_CYCLES` cycles, then goes to CHECK.
- CHECK state: one cycle. Sample the target HP (P_CHECK samples `AI_hp`; A_CHECK samples `p_hp`).
  - Knockout when HP == 0 or HP > `MAX_HP` (the latter is 4-bit underflow wrap).
- P_CHECK outcomes:
  - Knockout: go to OVER with `winner`=0.
  - Otherwise: go to A_SEL.
- A_CHECK outcomes:
  - Knockout: go to OVER with `winner`=1.
  - Otherwise: go to IDLE and increment `turn_cnt`, saturating at 255.
- OVER: `game_over`=1, `winner` held, all strobes 0. Only `rst` exits this state.
- `move_valid` outside IDLE is ignored; the move is not queued.
- The strobes `calc_dmg` and `app_dmg` are never high in the same cycle, and never high outside CALC/APPLY.

## Timing
- Reset (`rst`=0 at a clock edge), both from power-up and mid-turn:
  - state IDLE, `p_move`=0, `actr`=0, `target`=0, `calc_dmg`=0, `app_dmg`=0, `game_over`=0, `winner`=0, `turn_cnt`=0, settle counter 0.
  - `move_ready`=1 from the first cycle after reset.
- Outputs are Moore-decoded from registered state. A change is visible in the cycle after the edge that enters the state.
- Latency with S = `SETTLE_CYCLES`:
  - One half-turn takes 2S+3 cycles.
  - With accept at edge 0, `calc_dmg` is high in cycle S+1 and `app_dmg` in cycle S+2.
  - A full turn returns to IDLE after 4S+6 cycles (14 cycles for S=2).
- A move can be accepted in the first cycle of IDLE, so back-to-back turns have no dead cycle.
- HP is sampled only in CHECK states. Transient HP values in other states have no effect.

## Structure
- Shared package `pbs_pkg` holds:
  - the state enum;
  - `MAX_HP` = 4'd9;
  - `ACT_PLAYER`/`ACT_AI` and `TGT_PLAYER`/`TGT_AI` encodings, also used by `pbs_dp`.
- One sub-module, `pbs_settle_cnt`: 4-bit load/decrement counter with a `done` flag. It is reused for both the SEL and WAIT states.

## Test plan
- Reset, then `move_valid`=1 with `p_move_in`=2'b10 and S=2, no knockout:
  - `p_move`=2'b10;
  - `calc_dmg` in cycles 3 and 10, `app_dmg` in cycles 4 and 11;
  - `move_ready` back high at cycle 15;
  - `turn_cnt`=1.
- `AI_hp` driven to 0 before P_CHECK: `game_over`=1, `winner`=0; no AI-half strobes are ever issued; further `move_valid` pulses are ignored.
- `AI_hp`=5 and `p_hp`=4'hF (wrap) at A_CHECK: OVER with `winner`=1.
- `move_valid` pulsed during A_WAIT: ignored; `p_move` unchanged; a single IDLE entry follows.
- Assert `rst`=0 during P_APPLY: next cycle all outputs are at reset values and `move_ready`=1.
- 300 turns with no knockout: `turn_cnt` saturates at 255.
